interp_ctrl: RTL and testbench
==============================

# interp_ctrl

Sequencer for the Tx interpolation chain. It runs at the fast (output) clock rate and accepts one input sample per L-cycle frame over a valid/ready handshake. It produces the zero-stuffed sample stream plus the comb/integrator enable strobes for the CIC stages. It also handles start/stop sequencing, zero-flush of the filter state on stop, and underrun accounting.

## Interface
Parameters:
- `L`, default 8: interpolation factor, integer ≥ 2; `PW = $clog2(L)`.
- `width`, default 20: signed sample width.
- `FLUSH_FRAMES`, default 4: number of zero-input frames issued after stop to drain the CIC state; ≥ 1.
- `CNT_W`, default 16: underrun counter width.

Ports:
- `clk`, in, 1: fast clock, L× the input sample rate.
- `rst_n`, in, 1: asynchronous active-low reset.
- `enable`, in, 1: run request, level-sensitive.
- `clear_stat`, in, 1: synchronous clear of `underrun` and `underrun_cnt`.
- `in_valid`, in, 1: upstream sample valid.
- `in_data`, in, `width` (signed): upstream sample.
- `in_ready`, out, 1: sample accepted this cycle if `in_valid` is also high.
- `out_data`, out, `width` (signed): zero-stuffed stream to the integrators.
- `out_valid`, out, 1: `out_data` is a valid output-rate sample.
- `comb_en`, out, 1: one-cycle pulse per frame that advances the comb stages.
- `integ_en`, out, 1: integrator advance. Equal to `out_valid`.
- `phase`, out, `PW`: position within the current frame, 0..L-1.
- `busy`, out, 1: state is not IDLE.
- `underrun`, out, 1: sticky flag, set on any missed sample in RUN.
- `underrun_cnt`, out, `CNT_W`: count of missed samples, saturating.

## Operation
States are IDLE, RUN and FLUSH.

**IDLE**
- `phase` is held at 0.
- `in_ready`, `out_valid`, `comb_en`, `integ_en` = 0; `out_data` = 0.
- `enable` = 1 → RUN on the next edge, starting with `phase` = 0.

**RUN**
- `phase` increments every cycle and wraps L-1 → 0.
- `in_ready` = 1 only when `phase` == 0. It is a decode of registered state and phase, with no dependence on `in_valid`.
- `phase` == 0 with `in_valid` = 1: the sample is accepted.
  - `out_data` ← `in_data` at the next edge.
  - `comb_en` pulses for that cycle.
- `phase` == 0 with `in_valid` = 0: underrun.
  - `out_data` ← 0 and `comb_en` still pulses, so the frame rate is kept.
  - `underrun` ← 1 and `underrun_cnt` increments, saturating at all-ones.
- `phase` ≠ 0: `out_data` ← 0 and `in_data` is ignored.
- `out_valid` = `integ_en` = 1 for every cycle spent in RUN.
- Stop: when `phase` == L-1 and `enable` = 0 → FLUSH. Frames always complete; deasserting `enable` mid-frame takes effect at the frame end.

**FLUSH**
- Lasts exactly `FLUSH_FRAMES`·L cycles, with `phase` continuing to count.
- `in_ready` = 0; `out_data` = 0 throughout.
- `comb_en` pulses at `phase` == 0 (zero input to the combs); `out_valid` = `integ_en` = 1.
- No underrun is counted in FLUSH.
- On the last cycle of FLUSH (final frame, `phase` == L-1):
  - `enable` = 1 → RUN; `enable` = 0 → IDLE.
- Reasserting `enable` during FLUSH does not shorten the flush.

**Statistics**
- `clear_stat` = 1 zeroes `underrun` and `underrun_cnt` at the next edge.
- If a clear and an underrun occur in the same cycle, the clear wins: the result is 0, and the event is not counted.

**Reset**
- Asserting `rst_n` low at any time, including mid-frame or mid-flush, forces the following immediately:
  - state = IDLE, `phase` = 0.
  - `out_data` = 0; `underrun` = 0; `underrun_cnt` = 0.
  - All strobes = 0.

## Timing
- Handshake to output: 1 cycle. A sample accepted at edge k appears on `out_data` from edge k to edge k+1, followed by L-1 zero cycles.
- `comb_en` is high in the same cycle as the `phase` == 0 handshake slot, so the comb registers update on that edge with `in_data`.
- First `in_ready` comes 1 cycle after `enable` is sampled high in IDLE.
- Output cadence in RUN and FLUSH: exactly one `comb_en` per L cycles and `out_valid` on every cycle. There are no gaps between back-to-back frames or between RUN and FLUSH.
- Last `out_valid` occurs (`FLUSH_FRAMES`·L) cycles after the final RUN frame ends.
- `busy` drops on the edge that enters IDLE.
- All outputs are registered or pure decodes of registers; there are no combinational paths from inputs to outputs.

## Test plan
1. **Basic run.** L=8; `enable` held high; samples 100, -5, 7 offered continuously. Required: `out_data` = 100,0×7,-5,0×7,7,0×7; `comb_en` every 8th cycle; `underrun_cnt` = 0.
2. **Underrun.** Drop `in_valid` for frame 2 only. Required: that frame outputs 0×8; `comb_en` still pulses; `underrun` = 1; `underrun_cnt` = 1; the next frame resumes normally.
3. **Stop and flush.** Deassert `enable` at `phase` 3. Required: the frame finishes; then 32 zero cycles (FLUSH_FRAMES=4) with 4 `comb_en` pulses; `in_ready` = 0; then IDLE with `busy` = 0 and `out_valid` = 0.
4. **Restart during flush.** Reassert `enable` at flush cycle 10. Required: the flush runs the full 32 cycles, then RUN with `in_ready` at the next `phase` 0 and no IDLE cycle.
5. **Saturation and clear.** CNT_W=4 with 20 consecutive underruns. Required: the count stops at 15. Then pulse `clear_stat` on an underrun cycle. Required: `underrun_cnt` = 0 and `underrun` = 0 after the edge.
6. **Asynchronous reset.** Assert `rst_n` low mid-frame at `phase` 5 in RUN. Required: all outputs and `phase` go to 0 immediately, without waiting for a clock edge. After release, the block stays in IDLE until `enable` is high.

Source files
------------

// File: rtl/interp_ctrl_if.sv
// Sample handshake and CIC strobe bundle between the Tx interpolation
// sequencer, its upstream sample source and the downstream CIC stages.
interface interp_ctrl_if #(
    parameter int width = 20
);
    logic                    in_valid;
    logic signed [width-1:0] in_data;
    logic                    in_ready;
    logic signed [width-1:0] out_data;
    logic                    out_valid;
    logic                    comb_en;
    logic                    integ_en;

    modport master (
        output in_valid, in_data,
        input  in_ready, out_data, out_valid, comb_en, integ_en
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, out_data, out_valid, comb_en, integ_en
    );
endinterface

// File: rtl/interp_ctrl.sv
// Tx interpolation sequencer: one input sample per L-cycle frame, zero-stuffed
// output stream, CIC comb/integrator strobes, stop-time zero flush, underrun stats.
module interp_ctrl #(
    parameter int  L            = 8,
    parameter int  width        = 20,
    parameter int  FLUSH_FRAMES = 4,
    parameter int  CNT_W        = 16,
    localparam int PW           = $clog2(L)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             clear_stat,
    interp_ctrl_if.slave     bus,
    output logic [PW-1:0]    phase,
    output logic             busy,
    output logic             underrun,
    output logic [CNT_W-1:0] underrun_cnt
);

    localparam int FW = (FLUSH_FRAMES > 1) ? $clog2(FLUSH_FRAMES) : 1;
    localparam logic [PW-1:0] PH_LAST = PW'(L - 1);
    localparam logic [FW-1:0] FR_LAST = FW'(FLUSH_FRAMES - 1);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t                  state, state_nxt;
    logic [PW-1:0]           phase_nxt;
    logic [FW-1:0]           frame_cnt, frame_cnt_nxt;
    logic signed [width-1:0] data_q;
    logic                    slot, frame_last, take, miss;

    assign slot       = (phase == '0);
    assign frame_last = (phase == PH_LAST);
    assign take       = (state == RUN) && slot && bus.in_valid;
    assign miss       = (state == RUN) && slot && !bus.in_valid;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt     = state;
        phase_nxt     = phase;
        frame_cnt_nxt = frame_cnt;
        case (state)
            IDLE: begin
                phase_nxt = '0;
                if (enable) state_nxt = RUN;
            end
            RUN: begin
                phase_nxt = frame_last ? '0 : phase + PW'(1);
                if (frame_last && !enable) begin
                    state_nxt     = FLUSH;
                    frame_cnt_nxt = '0;
                end
            end
            FLUSH: begin
                // The flush always drains its full length; enable only picks the exit.
                phase_nxt = frame_last ? '0 : phase + PW'(1);
                if (frame_last) begin
                    if (frame_cnt == FR_LAST) state_nxt = enable ? RUN : IDLE;
                    else                      frame_cnt_nxt = frame_cnt + FW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                phase_nxt = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            phase     <= '0;
            frame_cnt <= '0;
            data_q    <= '0;
        end else begin
            state     <= state_nxt;
            phase     <= phase_nxt;
            frame_cnt <= frame_cnt_nxt;
            data_q    <= take ? bus.in_data : '0;
        end
    end

    // A clear in the same cycle as an underrun wins, so that event is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underrun     <= 1'b0;
            underrun_cnt <= '0;
        end else if (clear_stat) begin
            underrun     <= 1'b0;
            underrun_cnt <= '0;
        end else if (miss) begin
            underrun <= 1'b1;
            if (underrun_cnt != '1) underrun_cnt <= underrun_cnt + CNT_W'(1);
        end
    end

    assign busy         = (state != IDLE);
    assign bus.in_ready = (state == RUN) && slot;
    assign bus.comb_en  = busy && slot;
    assign bus.out_valid = busy;
    assign bus.integ_en = busy;
    assign bus.out_data = data_q;

endmodule

// File: tb/tb_interp_ctrl.sv
// Self-checking bench for interp_ctrl: randomized stimulus against a frame/flush
// level reference model, plus directed stop, restart, saturation and reset scenarios.
module tb_interp_ctrl;

    localparam int L  = 8;
    localparam int W  = 20;
    localparam int FF = 4;
    localparam int CW = 4;
    localparam int PW = 3;
    localparam int OW = 5 + PW + 1 + CW + W;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic          clear_stat;
    logic [PW-1:0] phase;
    logic          busy;
    logic          underrun;
    logic [CW-1:0] underrun_cnt;

    interp_ctrl_if #(.width(W)) bus();

    interp_ctrl #(
        .L(L), .width(W), .FLUSH_FRAMES(FF), .CNT_W(CW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .enable(enable),
        .clear_stat(clear_stat),
        .bus(bus),
        .phase(phase),
        .busy(busy),
        .underrun(underrun),
        .underrun_cnt(underrun_cnt)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: mode 0 idle, 1 run, 2 flush; position in frame; cycles of flush left.
    int                  m_mode;
    int                  m_pos;
    int                  m_flush_left;
    int                  m_ucnt;
    logic                m_urun;
    logic signed [W-1:0] m_out;

    task automatic m_reset();
        m_mode = 0; m_pos = 0; m_flush_left = 0;
        m_ucnt = 0; m_urun = 1'b0; m_out = '0;
    endtask

    task automatic model_step();
        logic slot;
        slot  = (m_mode == 1) && (m_pos == 0);
        m_out = (slot && bus.in_valid) ? bus.in_data : '0;
        if (clear_stat) begin
            m_urun = 1'b0; m_ucnt = 0;
        end else if (slot && !bus.in_valid) begin
            m_urun = 1'b1;
            if (m_ucnt < (1 << CW) - 1) m_ucnt++;
        end
        case (m_mode)
            0: if (enable) begin m_mode = 1; m_pos = 0; end
            1: begin
                if (m_pos == L - 1 && !enable) begin m_mode = 2; m_flush_left = FF * L; end
                m_pos = (m_pos + 1) % L;
            end
            default: begin
                m_flush_left--;
                m_pos = (m_pos + 1) % L;
                if (m_flush_left == 0) m_mode = enable ? 1 : 0;
            end
        endcase
    endtask

    function automatic logic [OW-1:0] dut_obs();
        return {busy, bus.in_ready, bus.out_valid, bus.integ_en, bus.comb_en,
                phase, underrun, underrun_cnt, bus.out_data};
    endfunction

    function automatic logic [OW-1:0] model_obs();
        logic b, r, c;
        b = (m_mode != 0);
        r = (m_mode == 1) && (m_pos == 0);
        c = b && (m_pos == 0);
        return {b, r, b, b, c, PW'(m_pos), m_urun, CW'(m_ucnt), m_out};
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_cycles(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            n_assert++;
            if (dut_obs() !== model_obs()) begin
                n_fail++;
                $display("FAIL %s: observed {busy,rdy,vld,integ,comb,phase,urun,cnt,data}=%h expected %h at %0t",
                         tag, dut_obs(), model_obs(), $time);
            end
            tick();
        end
    endtask

    task automatic align_to(input int p, input string tag);
        for (int i = 0; i < 64 && (m_mode == 0 || m_pos != p); i++) run_cycles(1, tag);
        n_assert++;
        if (phase !== PW'(p) || !busy) begin
            n_fail++;
            $display("FAIL %s_align: phase=%0d busy=%b, expected phase %0d while busy", tag, phase, busy, p);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1; enable = 1'b0; clear_stat = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = '0;
        m_reset();
        #2 rst_n = 1'b0;
        #1;
        n_assert++;
        if (dut_obs() !== '0) begin
            n_fail++;
            $display("FAIL reset_state: observed %h expected 0", dut_obs());
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        run_cycles(3, "reset_idle");
    endtask

    task automatic test_basic_run();
        logic signed [W-1:0] samples [3];
        logic signed [W-1:0] seen [25];
        logic signed [W-1:0] exp_v;
        int comb_cnt = 0;
        samples = '{20'sd100, -20'sd5, 20'sd7};
        enable = 1'b1; bus.in_valid = 1'b1; bus.in_data = '0;
        run_cycles(1, "basic_start");
        for (int c = 0; c < 25; c++) begin
            bus.in_data = (c < 24) ? samples[c / L] : W'($urandom);
            seen[c] = bus.out_data;
            if (c < 24) comb_cnt += int'(bus.comb_en);
            run_cycles(1, "basic_run");
        end
        for (int k = 0; k < 24; k++) begin
            exp_v = (k % L == 0) ? samples[k / L] : '0;
            n_assert++;
            if (seen[k + 1] !== exp_v) begin
                n_fail++;
                $display("FAIL basic_stream[%0d]: observed %0d expected %0d", k, seen[k + 1], exp_v);
            end
        end
        n_assert++;
        if (comb_cnt != 3 || underrun_cnt !== '0) begin
            n_fail++;
            $display("FAIL basic_comb_cnt: comb pulses %0d cnt %0d, expected 3 and 0", comb_cnt, underrun_cnt);
        end
    endtask

    task automatic test_underrun();
        int comb_cnt = 0;
        align_to(0, "underrun");
        for (int f = 0; f < 3; f++) begin
            for (int ph = 0; ph < L; ph++) begin
                bus.in_valid = (f != 1);
                bus.in_data  = W'($urandom);
                comb_cnt += int'(bus.comb_en);
                run_cycles(1, "underrun");
            end
        end
        bus.in_valid = 1'b1;
        n_assert++;
        if (underrun !== 1'b1 || underrun_cnt !== CW'(1) || comb_cnt != 3) begin
            n_fail++;
            $display("FAIL underrun_stats: urun=%b cnt=%0d comb=%0d, expected 1,1,3", underrun, underrun_cnt, comb_cnt);
        end
    endtask

    task automatic test_random_frames();
        for (int c = 0; c < 6 * L; c++) begin
            bus.in_valid = ($urandom_range(0, 9) != 0);
            bus.in_data  = W'($urandom);
            run_cycles(1, "random_frames");
        end
    endtask

    task automatic test_stop_flush();
        int busy_cnt = 0, comb_cnt = 0, rdy_cnt = 0;
        bus.in_valid = 1'b1;
        align_to(3, "stop");
        enable = 1'b0;
        for (int c = 0; c < 60; c++) begin
            busy_cnt += int'(busy);
            comb_cnt += int'(bus.comb_en);
            rdy_cnt  += int'(bus.in_ready);
            bus.in_data  = W'($urandom);
            bus.in_valid = $urandom_range(0, 1) != 0;
            run_cycles(1, "stop_flush");
        end
        n_assert++;
        if (busy_cnt != 5 + FF * L || comb_cnt != FF || rdy_cnt != 0) begin
            n_fail++;
            $display("FAIL stop_flush_len: busy=%0d comb=%0d ready=%0d, expected %0d,%0d,0",
                     busy_cnt, comb_cnt, rdy_cnt, 5 + FF * L, FF);
        end
        n_assert++;
        if (busy !== 1'b0 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stop_idle: busy=%b out_valid=%b, expected 0,0", busy, bus.out_valid);
        end
    endtask

    task automatic test_restart_flush();
        int first_ready = -1, idle_seen = 0;
        enable = 1'b1; bus.in_valid = 1'b1;
        align_to(6, "restart");
        enable = 1'b0;
        for (int i = 0; i < L && m_mode != 2; i++) run_cycles(1, "restart_enter");
        for (int fc = 0; fc < 40; fc++) begin
            if (fc == 10) enable = 1'b1;
            if (bus.in_ready && first_ready < 0) first_ready = fc;
            if (!busy) idle_seen++;
            bus.in_data = W'($urandom);
            run_cycles(1, "restart_flush");
        end
        n_assert++;
        if (first_ready != FF * L || idle_seen != 0) begin
            n_fail++;
            $display("FAIL restart_flush: first ready at flush cycle %0d idle cycles %0d, expected %0d and 0",
                     first_ready, idle_seen, FF * L);
        end
    endtask

    task automatic test_saturation_clear();
        enable = 1'b1;
        align_to(0, "saturate");
        bus.in_valid = 1'b0;
        run_cycles(20 * L, "saturate");
        n_assert++;
        if (underrun_cnt !== CW'(15) || underrun !== 1'b1) begin
            n_fail++;
            $display("FAIL saturate: cnt=%0d urun=%b, expected 15,1", underrun_cnt, underrun);
        end
        clear_stat = 1'b1;
        run_cycles(1, "clear_on_underrun");
        clear_stat = 1'b0;
        n_assert++;
        if (underrun_cnt !== '0 || underrun !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_wins: cnt=%0d urun=%b, expected 0,0", underrun_cnt, underrun);
        end
        bus.in_valid = 1'b1;
        run_cycles(L, "after_clear");
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 39) == 0) enable = ~enable;
            bus.in_valid = ($urandom_range(0, 7) != 0);
            clear_stat   = ($urandom_range(0, 49) == 0);
            bus.in_data  = W'($urandom);
            run_cycles(1, "random");
        end
        clear_stat = 1'b0;
    endtask

    task automatic test_async_reset();
        enable = 1'b1; bus.in_valid = 1'b0;
        align_to(5, "async_reset");
        #2;
        rst_n = 1'b0; enable = 1'b0;
        #1;
        n_assert++;
        if (dut_obs() !== '0) begin
            n_fail++;
            $display("FAIL async_reset: observed %h expected 0 before any clock edge", dut_obs());
        end
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        run_cycles(6, "post_reset_idle");
        n_assert++;
        if (busy !== 1'b0 || phase !== '0) begin
            n_fail++;
            $display("FAIL post_reset_idle: busy=%b phase=%0d, expected 0,0", busy, phase);
        end
        enable = 1'b1; bus.in_valid = 1'b1; bus.in_data = 20'sd1234;
        run_cycles(3, "post_reset_run");
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic_run();
        test_underrun();
        test_random_frames();
        test_stop_flush();
        test_restart_flush();
        test_saturation_clear();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
